// File: rtl/conv_pkg.sv
// Shared constants and window tap layout for the 3x3 convolution path.
// The multiply/sum unit uses tap_offset to locate each tap in the packed window.
package conv_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int WIN_DIM   = 3;
  localparam int WIN_TAPS  = WIN_DIM * WIN_DIM;
  localparam int WIN_W     = WIN_TAPS * PIX_W_DEF;

  // Emit qualifiers decoded from the raster position of the accepted pixel.
  typedef struct packed {
    logic row_ok;
    logic col_ok;
    logic frame_end;
  } emit_t;

  // Bit offset of tap (row, col); w00 sits at the MSB end, w22 at bit 0.
  function automatic int unsigned tap_offset(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned pix_w);
    return (WIN_TAPS - 1 - (row * WIN_DIM + col)) * pix_w;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-row pixel delay: reads and writes the same column, advancing only on accept.
// Contents are never cleared; the caller's row counter keeps stale data out of windows.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PIX_W = PIX_W_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Read returns last row's pixel at this column before the write replaces it.
  assign dout = mem[idx];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[idx] <= din;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line buffers feed a 3x3 shift array.
// Optional CONV_WINDOW_COORD_EN adds registered window-centre coordinates.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int PIX_W      = PIX_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PIX_W-1:0]              in_pixel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIN_TAPS*PIX_W-1:0]     out_window,
  output logic                          out_last
`ifdef CONV_WINDOW_COORD_EN
  ,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_col
`endif
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PIX_W-1:0] win_q [WIN_DIM][WIN_DIM];
  logic [PIX_W-1:0] win_d [WIN_DIM][WIN_DIM];
  logic [WIN_TAPS*PIX_W-1:0] window_d;
  logic [PIX_W-1:0] lb0_q;
  logic [PIX_W-1:0] lb1_q;
  logic accept;
  emit_t emit;

  // Handshake: a transfer happens on a side when valid && ready at posedge.
  // The single output stage frees up when empty or when its window is taken.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  conv_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .PIX_W (PIX_W),
    .IDX_W (COL_W)
  ) lb0 (
    .clk  (clk),
    .en   (accept),
    .idx  (col),
    .din  (in_pixel),
    .dout (lb0_q)
  );

  conv_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .PIX_W (PIX_W),
    .IDX_W (COL_W)
  ) lb1 (
    .clk  (clk),
    .en   (accept),
    .idx  (col),
    .din  (lb0_q),
    .dout (lb1_q)
  );

  always_comb begin
    for (int r = 0; r < WIN_DIM; r++) begin
      for (int c = 0; c < WIN_DIM - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
      win_d[r][WIN_DIM-1] = win_q[r][WIN_DIM-1];
    end
    win_d[0][WIN_DIM-1] = lb1_q;
    win_d[1][WIN_DIM-1] = lb0_q;
    win_d[2][WIN_DIM-1] = in_pixel;
  end

  always_comb begin
    window_d = '0;
    for (int r = 0; r < WIN_DIM; r++) begin
      for (int c = 0; c < WIN_DIM; c++) begin
        window_d[tap_offset(r, c, PIX_W) +: PIX_W] = win_d[r][c];
      end
    end
  end

  always_comb begin
    emit           = '0;
    emit.row_ok    = (row >= ROW_W'(2));
    emit.col_ok    = (col >= COL_W'(2));
    emit.frame_end = (row == ROW_MAX) && (col == COL_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        for (int c = 0; c < WIN_DIM; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      win_q <= win_d;
    end
  end

  // Load takes priority so a consume and a new window can share one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_window <= '0;
      out_last   <= 1'b0;
    end else if (accept && emit.row_ok && emit.col_ok) begin
      out_valid  <= 1'b1;
      out_window <= window_d;
      out_last   <= emit.frame_end;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end
  end

`ifdef CONV_WINDOW_COORD_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_row <= '0;
      out_col <= '0;
    end else if (accept && emit.row_ok && emit.col_ok) begin
      out_row <= row - 1'b1;
      out_col <= col - 1'b1;
    end
  end
`endif

endmodule
